// File: rtl/board_guess_checker_pkg.sv
// Shared definitions for the tile-memory game: board size, tile index width and checker states.
package board_guess_checker_pkg;
   localparam int N_TILES    = 8;
   localparam int TILE_IDX_W = 3;
   localparam int CNT_W      = 4;
   localparam int ST_W       = 3;

   typedef enum logic [ST_W-1:0] {
      S_IDLE  = 3'd0,
      S_SHOW  = 3'd1,
      S_GUESS = 3'd2,
      S_WIN   = 3'd3,
      S_LOSE  = 3'd4
   } state_t;
endpackage

// File: rtl/board_guess_checker_if.sv
// Board interface between the generator/front end (master) and the guess checker (slave).
interface board_guess_checker_if;
   import board_guess_checker_pkg::*;

   logic                  board_load;
   logic [N_TILES-1:0]    board;
   logic                  guess_valid;
   logic [TILE_IDX_W-1:0] guess_idx;
   logic                  show;
   logic [N_TILES-1:0]    pattern;
   logic [N_TILES-1:0]    revealed;
   logic [N_TILES-1:0]    wrong_mask;
   logic [CNT_W-1:0]      hits;
   logic [CNT_W-1:0]      misses;
   logic                  busy;
   logic                  win;
   logic                  lose;

   modport master (
      output board_load, board, guess_valid, guess_idx,
      input  show, pattern, revealed, wrong_mask, hits, misses, busy, win, lose
   );

   modport slave (
      input  board_load, board, guess_valid, guess_idx,
      output show, pattern, revealed, wrong_mask, hits, misses, busy, win, lose
   );
endinterface

// File: rtl/board_guess_checker_show_timer.sv
// Display-period timer: counts run cycles and pulses expired on the last of SHOW_CYCLES.
module show_timer #(
   parameter int SHOW_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int              TW   = $clog2(SHOW_CYCLES + 1);
   localparam logic [TW-1:0]   LAST = TW'(SHOW_CYCLES - 1);

   logic [TW-1:0] count_q;

   assign expired = run && !clear && (count_q == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= expired ? '0 : count_q + TW'(1);
      end
   end
endmodule

// File: rtl/board_guess_checker.sv
// Latches a board pattern, shows it for a fixed period, then scores tile guesses until WIN or LOSE.
//   state   | meaning
//   S_IDLE  | no round loaded since reset
//   S_SHOW  | pattern on display, guesses ignored
//   S_GUESS | pattern hidden, scoring guesses
//   S_WIN   | every lit tile found, results held
//   S_LOSE  | MAX_MISSES wrong tiles, results held
module board_guess_checker
   import board_guess_checker_pkg::*;
#(
   parameter int SHOW_CYCLES = 50_000_000,
   parameter int MAX_MISSES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   board_guess_checker_if.slave bif
);
   state_t             state_q, state_d;
   logic [N_TILES-1:0] pattern_q, revealed_q, wrong_q, gbit;
   logic [CNT_W-1:0]   hits_q, misses_q;
   logic               expired, taken, hit, miss;

   show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_show_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (bif.board_load),
      .run     (state_q == S_SHOW),
      .expired (expired)
   );

   assign gbit  = N_TILES'(1) << bif.guess_idx;
   assign taken = |((revealed_q | wrong_q) & gbit);

   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      miss    = 1'b0;
      case (state_q)
         S_SHOW: begin
            if (expired) state_d = (pattern_q == '0) ? S_WIN : S_GUESS;
         end
         S_GUESS: begin
            if (bif.guess_valid && !bif.board_load && !taken) begin
               hit  = |(pattern_q & gbit);
               miss = !hit;
            end
            if (hit && ((revealed_q | gbit) == pattern_q)) state_d = S_WIN;
            else if (miss && (misses_q + CNT_W'(1) == CNT_W'(MAX_MISSES))) state_d = S_LOSE;
         end
         default: state_d = state_q;
      endcase
      // A new board wins over everything, including a same-cycle guess.
      if (bif.board_load) state_d = S_SHOW;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pattern_q  <= '0;
         revealed_q <= '0;
         wrong_q    <= '0;
         hits_q     <= '0;
         misses_q   <= '0;
      end else begin
         state_q <= state_d;
         if (bif.board_load) begin
            pattern_q  <= bif.board;
            revealed_q <= '0;
            wrong_q    <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
         end else begin
            if (hit) begin
               revealed_q <= revealed_q | gbit;
               hits_q     <= hits_q + CNT_W'(1);
            end
            if (miss) begin
               wrong_q  <= wrong_q | gbit;
               misses_q <= misses_q + CNT_W'(1);
            end
         end
      end
   end

   assign bif.show       = (state_q == S_SHOW);
   assign bif.busy       = (state_q == S_SHOW) || (state_q == S_GUESS);
   assign bif.win        = (state_q == S_WIN);
   assign bif.lose       = (state_q == S_LOSE);
   assign bif.pattern    = pattern_q;
   assign bif.revealed   = revealed_q;
   assign bif.wrong_mask = wrong_q;
   assign bif.hits       = hits_q;
   assign bif.misses     = misses_q;
endmodule
